// File: rtl/fwd_pkg.sv
// Shared types and encodings for the operand-forwarding controller.
// Select codes, scoreboard entry layout and the match helper.
package fwd_pkg;

  localparam int FWD_REG_AW = 3;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_WB    = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] dst;
    logic                  wr_en;
    logic                  is_load;
  } sb_entry_t;

  // r0 never forwards: it reads as zero regardless of writers.
  function automatic logic ent_match(
    input sb_entry_t             e,
    input logic [FWD_REG_AW-1:0] src,
    input logic                  used
  );
    return e.valid & e.wr_en & used
         & (src != '0) & (e.dst == src);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority comparator for one source operand against S1..S3.
// WB-stage forwarding is enabled by defining FWD_WB_EN.
module fwd_match
  import fwd_pkg::*;
(
  input  logic [FWD_REG_AW-1:0] i_src,
  input  logic                  i_used,
  input  sb_entry_t             i_s1,
  input  sb_entry_t             i_s2,
  input  sb_entry_t             i_s3,
  output logic [1:0]            o_sel,
  output logic                  o_load_hit
);

  logic w_m1;
  logic w_m2;
  logic w_m3;

  assign w_m1 = ent_match(i_s1, i_src, i_used);
  assign w_m2 = ent_match(i_s2, i_src, i_used);
  assign w_m3 = ent_match(i_s3, i_src, i_used);

  assign o_load_hit = w_m1 & i_s1.is_load;

  always_comb begin
    o_sel = SEL_RF;
    if (w_m1) begin
      o_sel = SEL_EXMEM;
    end else if (w_m2) begin
      o_sel = SEL_MEMWB;
    end else if (w_m3) begin
`ifdef FWD_WB_EN
      o_sel = SEL_WB;
`else
      // write-through RF already holds the WB value
      o_sel = SEL_RF;
`endif
    end
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Forwarding select and load-use stall controller (EX/MEM/WB scoreboard).
// Define FWD_WB_EN to forward from the WB holding register (sel 11).
module fwd_sel_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall
);

  sb_entry_t  r_s1;
  sb_entry_t  r_s2;
  sb_entry_t  r_s3;
  logic [1:0] r_sel_a;
  logic [1:0] r_sel_b;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_hit_a;
  logic       w_hit_b;
  logic       w_issue;
  sb_entry_t  w_new;

  fwd_match u_match_a (
    .i_src      (id_rs),
    .i_used     (id_rs_used),
    .i_s1       (r_s1),
    .i_s2       (r_s2),
    .i_s3       (r_s3),
    .o_sel      (w_sel_a),
    .o_load_hit (w_hit_a)
  );

  fwd_match u_match_b (
    .i_src      (id_rt),
    .i_used     (id_rt_used),
    .i_s1       (r_s1),
    .i_s2       (r_s2),
    .i_s3       (r_s3),
    .o_sel      (w_sel_b),
    .o_load_hit (w_hit_b)
  );

  // flush wins over stall: a squashed consumer never waits
  assign stall   = id_valid & ~flush & (w_hit_a | w_hit_b);
  assign w_issue = id_valid & ~flush & ~stall;

  always_comb begin
    w_new         = '0;
    w_new.valid   = w_issue;
    w_new.dst     = id_dst;
    w_new.wr_en   = id_wr_en;
    w_new.is_load = id_is_load;
    if (!w_issue) begin
      w_new = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else begin
      r_s3    <= r_s2;
      r_s2    <= r_s1;
      r_s1    <= w_new;
      r_sel_a <= w_issue ? w_sel_a : SEL_RF;
      r_sel_b <= w_issue ? w_sel_b : SEL_RF;
    end
  end

  assign sel_a = r_sel_a;
  assign sel_b = r_sel_b;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed table plus random
// stimulus against a history-based reference model.
module tb_fwd_sel_ctrl;

`ifdef FWD_WB_EN
  localparam logic [1:0] SEL3 = 2'b11;
`else
  localparam logic [1:0] SEL3 = 2'b00;
`endif

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [2:0] id_dst;
  logic       id_wr_en;
  logic       id_is_load;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;

  fwd_sel_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_dst     (id_dst),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rsu;
    logic       rtu;
    logic [2:0] dst;
    logic       wr;
    logic       ld;
    logic       fl;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
  } vec_t;

  // model: last three issue slots, youngest first
  typedef struct {
    bit v;
    int d;
    bit w;
    bit l;
  } slot_t;

  slot_t hist[3];
  int    nvec;
  int    nerr;

  function automatic in_t mk(
    input logic v, input int rs, input int rt,
    input logic rsu, input logic rtu,
    input int dst, input logic wr,
    input logic ld, input logic fl
  );
    in_t x;
    x.v   = v;
    x.rs  = 3'(rs);
    x.rt  = 3'(rt);
    x.rsu = rsu;
    x.rtu = rtu;
    x.dst = 3'(dst);
    x.wr  = wr;
    x.ld  = ld;
    x.fl  = fl;
    return x;
  endfunction

  // distance (0..2) to the youngest in-flight writer, 3 = none
  function automatic int youngest(input int src, input bit used);
    if (!used || src == 0) return 3;
    for (int k = 0; k < 3; k++)
      if (hist[k].v && hist[k].w && hist[k].d == src) return k;
    return 3;
  endfunction

  function automatic logic [1:0] dist_sel(input int k);
    case (k)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return SEL3;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one cycle: drive, check stall before the edge, sel after it
  task automatic step(input in_t x, input bit use_tbl,
                      input logic t_st, input logic [1:0] t_sa,
                      input logic [1:0] t_sb, input string nm);
    int  da, db;
    bit  m_st, iss;
    logic [1:0] m_sa, m_sb;
    id_valid   = x.v;
    id_rs      = x.rs;
    id_rt      = x.rt;
    id_rs_used = x.rsu;
    id_rt_used = x.rtu;
    id_dst     = x.dst;
    id_wr_en   = x.wr;
    id_is_load = x.ld;
    flush      = x.fl;
    @(negedge clk);
    da   = youngest(int'(x.rs), x.rsu);
    db   = youngest(int'(x.rt), x.rtu);
    m_st = x.v && !x.fl && hist[0].l && (da == 0 || db == 0);
    iss  = x.v && !x.fl && !m_st;
    m_sa = (iss && rst_n) ? dist_sel(da) : 2'b00;
    m_sb = (iss && rst_n) ? dist_sel(db) : 2'b00;
    chk({nm, ".stall"}, {1'b0, stall},
        {1'b0, use_tbl ? t_st : logic'(m_st)});
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{iss, int'(x.dst), x.wr, x.ld};
    end
    #1;
    chk({nm, ".sel_a"}, sel_a, use_tbl ? t_sa : m_sa);
    chk({nm, ".sel_b"}, sel_b, use_tbl ? t_sb : m_sb);
  endtask

  vec_t tbl[20];
  in_t  haz;
  in_t  rin;

  initial begin
    nvec = 0;
    nerr = 0;
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};

    // rows: v rs rt rsu rtu dst wr ld fl -> stall sa sb
    tbl[0]  = '{mk(1,1,2,1,1,3,1,0,0), 0, 2'b00, 2'b00};
    tbl[1]  = '{mk(1,3,4,1,1,7,1,0,0), 0, 2'b01, 2'b00};
    tbl[2]  = '{mk(1,1,1,1,1,6,1,0,0), 0, 2'b00, 2'b00};
    tbl[3]  = '{mk(1,7,3,1,1,1,1,0,0), 0, 2'b10, SEL3};
    tbl[4]  = '{mk(1,0,0,0,0,2,1,1,0), 0, 2'b00, 2'b00};
    tbl[5]  = '{mk(1,5,2,1,1,4,1,0,0), 1, 2'b00, 2'b00};
    tbl[6]  = '{mk(1,5,2,1,1,4,1,0,0), 0, 2'b00, 2'b10};
    tbl[7]  = '{mk(1,1,1,1,1,0,1,0,0), 0, 2'b00, 2'b00};
    tbl[8]  = '{mk(1,0,4,1,0,5,1,0,0), 0, 2'b00, 2'b00};
    tbl[9]  = '{mk(1,1,1,0,0,5,1,0,0), 0, 2'b00, 2'b00};
    tbl[10] = '{mk(1,5,5,1,1,2,0,0,0), 0, 2'b01, 2'b01};
    tbl[11] = '{mk(1,0,0,0,0,3,1,1,0), 0, 2'b00, 2'b00};
    tbl[12] = '{mk(1,3,3,1,1,1,1,0,1), 0, 2'b00, 2'b00};
    tbl[13] = '{mk(1,3,0,1,0,4,1,1,0), 0, 2'b10, 2'b00};
    tbl[14] = '{mk(1,0,0,0,0,5,1,1,0), 0, 2'b00, 2'b00};
    tbl[15] = '{mk(1,4,5,1,1,6,1,0,0), 1, 2'b00, 2'b00};
    tbl[16] = '{mk(1,4,5,1,1,6,1,0,0), 0, SEL3,  2'b10};
    tbl[17] = '{mk(0,6,6,1,1,1,1,0,0), 0, 2'b00, 2'b00};
    tbl[18] = '{mk(1,6,6,1,1,1,1,0,0), 0, 2'b10, 2'b10};
    tbl[19] = '{mk(1,1,1,1,1,2,1,0,0), 0, 2'b01, 2'b01};

    // reset held two cycles under hazardous stimulus
    rst_n = 1'b0;
    haz = mk(1, 2, 2, 1, 1, 2, 1, 1, 0);
    step(haz, 1, 0, 2'b00, 2'b00, "rst0");
    step(haz, 1, 0, 2'b00, 2'b00, "rst1");
    rst_n = 1'b1;
    step(mk(1,3,4,1,1,5,1,0,0), 1, 0, 2'b00, 2'b00,
         "first");

    // fresh scoreboard history for the table
    step(mk(0,0,0,0,0,0,0,0,0), 1, 0, 2'b00, 2'b00, "idle0");
    step(mk(0,0,0,0,0,0,0,0,0), 1, 0, 2'b00, 2'b00, "idle1");
    step(mk(0,0,0,0,0,0,0,0,0), 1, 0, 2'b00, 2'b00, "idle2");

    for (int n = 0; n < 20; n++)
      step(tbl[n].i, 1, tbl[n].st, tbl[n].sa, tbl[n].sb,
           $sformatf("tbl%0d", n));

    // mid-run reset discards an in-flight load
    step(mk(1,0,0,0,0,2,1,1,0), 1, 0, 2'b00, 2'b00, "mid.ld");
    rst_n = 1'b0;
    step(mk(1,2,2,1,1,3,1,0,0), 1, 1, 2'b00, 2'b00, "mid.r0");
    step(mk(1,2,2,1,1,3,1,0,0), 1, 0, 2'b00, 2'b00, "mid.r1");
    rst_n = 1'b1;
    step(mk(1,2,2,1,1,3,1,0,0), 1, 0, 2'b00, 2'b00, "mid.use");

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      rin.v   = ($urandom_range(0, 7) != 0);
      rin.rs  = 3'($urandom_range(0, 4));
      rin.rt  = 3'($urandom_range(0, 4));
      rin.rsu = ($urandom_range(0, 5) != 0);
      rin.rtu = ($urandom_range(0, 5) != 0);
      rin.dst = 3'($urandom_range(0, 4));
      rin.wr  = ($urandom_range(0, 5) != 0);
      rin.ld  = ($urandom_range(0, 2) == 0);
      rin.fl  = ($urandom_range(0, 9) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      step(rin, 0, 0, 2'b00, 2'b00, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
# fwd_sel_ctrl

Forwarding and load-use hazard controller for the 16-bit pipelined datapath. It tracks the destination registers of instructions in flight in EX, MEM and WB, and drives the 2-bit select of the two 16-bit 4:1 operand muxes at the ALU inputs. It also raises a stall when the consumer depends on a load that is still in EX. It sits between the ID/EX pipeline register and the operand muxes.

## Interface
- REG_AW, 3: register-address width (8 architectural registers; r0 is hardwired zero).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- id_valid  in  1  ID holds a real instruction that is ready to issue into EX.
- id_rs, id_rt  in  REG_AW  source register addresses of the ID instruction.
- id_rs_used, id_rt_used  in  1  the ID instruction actually reads rs or rt.
- id_dst  in  REG_AW  destination register of the ID instruction.
- id_wr_en  in  1  the ID instruction writes id_dst.
- id_is_load  in  1  the ID instruction is a memory load.
- flush  in  1  squash the ID instruction (taken branch).
- sel_a, sel_b  out  2  registered operand-mux selects:
  - 00 = register file
  - 01 = EX/MEM result
  - 10 = MEM/WB result
  - 11 = WB holding register
- stall  out  1  combinational; holds PC and IF/ID and inserts a bubble into EX.

## Operation
- Internal scoreboard has three stages, S1 (EX), S2 (MEM) and S3 (WB).
  - Each entry holds {valid, dst, wr_en, is_load}.
- Every edge, entries shift: S3 <= S2, S2 <= S1.
- S1 loads from the ID inputs only if id_valid & !stall & !flush. Otherwise S1 loads a bubble (valid=0).
- An entry "matches" a source register when all of these hold: valid, wr_en, dst == src, src != 0, and the src_used flag is set.
- At each edge, each select is loaded independently. The nearest match wins:
  - S1 match -> 01
  - else S2 match -> 10
  - else S3 match -> 11
  - else 00
- If the ID instruction does not issue (stall, flush or !id_valid), sel_a and sel_b load 00.
- stall = id_valid & !flush & S1.valid & S1.wr_en & S1.is_load & (S1 matches rs or rt).
- After a stall cycle, the load has moved to S2. The held consumer therefore issues the next cycle with sel 10.
- flush has priority over stall. A flushed ID instruction produces no stall and enters S1 as a bubble.
- Consecutive writes to the same register resolve to the youngest producer (nearest stage).

## Timing
- Reset (rst_n=0 at an edge) produces the following, with priority over all other inputs:
  - all scoreboard entries invalid
  - sel_a = sel_b = 00
  - stall = 0 (combinational, because S1 is invalid)
- Reset asserted mid-operation discards all in-flight hazard state. The first instruction after reset always gets sel 00.
- Select latency is 1 cycle. The selects are computed from the ID inputs at edge N and are valid for the whole of EX cycle N..N+1, which is the cycle the consumer occupies EX.
- stall has zero latency. It is valid in the same cycle as the ID inputs and depends only on the ID inputs and S1.
- A load-use dependency costs exactly one bubble. Back-to-back loads feeding a consumer still cost exactly one bubble.

## Configuration
- FWD_WB_EN defined:
  - S3 matches are forwarded with sel 11.
  - The datapath provides the WB holding register.
- FWD_WB_EN undefined:
  - S3 is not compared, and sel never takes the value 11.
  - The register file must be write-before-read (write-through) in that case.
  - S3 is still shifted so that flush and reset behaviour is unchanged.

## Structure
- Shared package fwd_pkg holds:
  - the select encodings SEL_RF=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10, SEL_WB=2'b11
  - the scoreboard entry typedef
  - the REG_AW default
- Sub-module fwd_match: combinational priority comparator that takes one source register plus its used flag and the three entries, and returns a select code and a load-hit flag. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with hazardous stimulus -> sel_a=sel_b=00 and stall=0. The first instruction after release gets 00.
- ALU chain: issue add r3 (dst=3), then add using rs=3 -> sel_a=01 in the consumer's EX cycle. Inserting one independent instruction between them gives sel_a=10 instead.
- Load-use: issue a load into r2, then a consumer with rt=2 -> stall=1 for exactly 1 cycle and S1 holds a bubble. The consumer then issues with sel_b=10.
- r0 and unused sources: the producer writes dst=0 and the consumer reads rs=0 -> sel_a=00. A dst match with rt_used=0 -> sel_b=00.
- Youngest wins: two writers to r5 in consecutive cycles, then a reader of r5 -> sel=01, not 10.
- Distance 3 with FWD_WB_EN defined -> sel=11. With it undefined -> sel=00. Asserting flush during a load-use hazard -> stall=0 and a bubble enters S1.
